i2c_reg_arbiter: RTL

- Two-port arbiter sharing one register target between two pulse-handshake requesters.
- Port 0 is the I2C slave core's register interface; port 1 is a local requester such as an internal sequencer or debug bridge.
- Each requester's single-cycle request is captured into a pending slot, then granted round-robin, forwarded to the target, and completed by routing the target's response pulse and read data back to the originator.
- Optional timeout keeps a hung target from stalling the I2C bus.

---
 rtl/i2c_reg_arbiter.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_arbiter
//  Description : Two-port round-robin arbiter sharing one register target.
//                Port 0 serves the I2C slave core and port 1 a local requester.
//                Each port's request pulse is captured into a pending slot.
//                The slot is forwarded to the target, and the target's
//                response is routed back to the port that owns the transfer.
//                Optional macro I2C_REG_ARBITER_TIMEOUT_EN adds a WAIT-state
//                timeout that completes a hung transfer with read data 8'hFF.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_arbiter #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] m0_address,
  input  logic                     m0_is_write,
  input  logic [7:0]               m0_write_data,
  input  logic                     m0_request,
  output logic                     m0_response,
  output logic [7:0]               m0_read_data,
  input  logic [ADDRESS_WIDTH-1:0] m1_address,
  input  logic                     m1_is_write,
  input  logic [7:0]               m1_write_data,
  input  logic                     m1_request,
  output logic                     m1_response,
  output logic [7:0]               m1_read_data,
  output logic [ADDRESS_WIDTH-1:0] t_address,
  output logic                     t_is_write,
  output logic [7:0]               t_write_data,
  output logic                     t_request,
  input  logic                     t_response,
  input  logic [7:0]               t_read_data,
  output logic [1:0]               grant,
  output logic [1:0]               overrun,
  output logic                     timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Elaboration-time guard on the timeout range (the counter is 16 bits wide)
  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("i2c_reg_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end
  endgenerate

  // Per-port request views so the slot logic can loop over ports
  logic [1:0]               w_req;
  logic [1:0]               w_in_wr;
  logic [ADDRESS_WIDTH-1:0] w_in_addr [2];
  logic [7:0]               w_in_wd   [2];

  assign w_req        = {m1_request, m0_request};
  assign w_in_wr      = {m1_is_write, m0_is_write};
  assign w_in_addr[0] = m0_address;
  assign w_in_addr[1] = m1_address;
  assign w_in_wd[0]   = m0_write_data;
  assign w_in_wd[1]   = m1_write_data;

  // Pending slots
  logic [1:0]               r_pend;
  logic [1:0]               r_slot_wr;
  logic [ADDRESS_WIDTH-1:0] r_slot_addr [2];
  logic [7:0]               r_slot_wd   [2];
  logic [1:0]               r_overrun;
  logic [1:0]               w_clear;

  // FSM and registered outputs
  state_t                   r_state, w_state_next;
  logic [1:0]               r_grant, w_grant_next;
  logic [ADDRESS_WIDTH-1:0] r_t_address, w_t_address_next;
  logic                     r_t_is_write, w_t_is_write_next;
  logic [7:0]               r_t_write_data, w_t_write_data_next;
  logic                     r_t_request, w_t_request_next;
  logic [1:0]               r_resp, w_resp_next;
  logic [7:0]               r_rd0, w_rd0_next;
  logic [7:0]               r_rd1, w_rd1_next;
  logic                     r_last, w_last_next;
  logic                     w_pick1;
  logic                     w_tmo_hit;
  logic                     w_done;
  logic [7:0]               w_resp_data;

`ifdef I2C_REG_ARBITER_TIMEOUT_EN
  logic [15:0] r_wait_cnt, w_wait_cnt_next;
  logic        r_timeout, w_timeout_next;

  assign w_tmo_hit = (r_state == ST_WAIT) && (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign timeout   = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  // A transfer completes on the target response, or on timeout if enabled;
  // a real response in the terminal cycle wins and returns real data.
  assign w_done      = (r_state == ST_WAIT) && (t_response || w_tmo_hit);
  assign w_clear     = w_done ? r_grant : 2'b00;
  assign w_resp_data = t_response ? t_read_data : 8'hFF;

  // Both pending: serve the port that was not served last; else the only one
  assign w_pick1 = r_pend[1] && (!r_pend[0] || !r_last);

  // Slot capture: an empty slot latches the request, a full one flags overrun
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend    <= 2'b00;
      r_slot_wr <= 2'b00;
      r_overrun <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        r_slot_addr[n] <= '0;
        r_slot_wd[n]   <= 8'h00;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (w_clear[n]) begin
          r_pend[n] <= 1'b0;
        end
        if (w_req[n] && !r_pend[n]) begin
          r_pend[n]      <= 1'b1;
          r_slot_wr[n]   <= w_in_wr[n];
          r_slot_addr[n] <= w_in_addr[n];
          r_slot_wd[n]   <= w_in_wd[n];
        end
        if (w_req[n] && r_pend[n]) begin
          r_overrun[n] <= 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT sequencer
  always_comb begin
    w_state_next        = r_state;
    w_grant_next        = r_grant;
    w_t_address_next    = r_t_address;
    w_t_is_write_next   = r_t_is_write;
    w_t_write_data_next = r_t_write_data;
    w_t_request_next    = 1'b0;
    w_resp_next         = 2'b00;
    w_rd0_next          = r_rd0;
    w_rd1_next          = r_rd1;
    w_last_next         = r_last;
`ifdef I2C_REG_ARBITER_TIMEOUT_EN
    w_wait_cnt_next     = r_wait_cnt;
    w_timeout_next      = r_timeout;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_grant_next        = w_pick1 ? 2'b10 : 2'b01;
          w_t_address_next    = w_pick1 ? r_slot_addr[1] : r_slot_addr[0];
          w_t_is_write_next   = w_pick1 ? r_slot_wr[1]   : r_slot_wr[0];
          w_t_write_data_next = w_pick1 ? r_slot_wd[1]   : r_slot_wd[0];
          w_t_request_next    = 1'b1;
          w_state_next        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Any target response during the request cycle is ignored
        w_state_next = ST_WAIT;
`ifdef I2C_REG_ARBITER_TIMEOUT_EN
        w_wait_cnt_next = 16'd0;
`endif
      end
      ST_WAIT: begin
`ifdef I2C_REG_ARBITER_TIMEOUT_EN
        w_wait_cnt_next = r_wait_cnt + 16'd1;
        if (w_done && !t_response) begin
          w_timeout_next = 1'b1;
        end
`endif
        if (w_done) begin
          w_resp_next  = r_grant;
          w_last_next  = r_grant[1];
          w_grant_next = 2'b00;
          w_state_next = ST_IDLE;
          if (r_grant[0]) begin
            w_rd0_next = w_resp_data;
          end
          if (r_grant[1]) begin
            w_rd1_next = w_resp_data;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = 2'b00;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_grant        <= 2'b00;
      r_t_address    <= '0;
      r_t_is_write   <= 1'b0;
      r_t_write_data <= 8'h00;
      r_t_request    <= 1'b0;
      r_resp         <= 2'b00;
      r_rd0          <= 8'h00;
      r_rd1          <= 8'h00;
      r_last         <= 1'b1;
`ifdef I2C_REG_ARBITER_TIMEOUT_EN
      r_wait_cnt     <= 16'd0;
      r_timeout      <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_next;
      r_grant        <= w_grant_next;
      r_t_address    <= w_t_address_next;
      r_t_is_write   <= w_t_is_write_next;
      r_t_write_data <= w_t_write_data_next;
      r_t_request    <= w_t_request_next;
      r_resp         <= w_resp_next;
      r_rd0          <= w_rd0_next;
      r_rd1          <= w_rd1_next;
      r_last         <= w_last_next;
`ifdef I2C_REG_ARBITER_TIMEOUT_EN
      r_wait_cnt     <= w_wait_cnt_next;
      r_timeout      <= w_timeout_next;
`endif
    end
  end

  assign m0_response  = r_resp[0];
  assign m1_response  = r_resp[1];
  assign m0_read_data = r_rd0;
  assign m1_read_data = r_rd1;
  assign t_address    = r_t_address;
  assign t_is_write   = r_t_is_write;
  assign t_write_data = r_t_write_data;
  assign t_request    = r_t_request;
  assign grant        = r_grant;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
